pingpong_frame_writer: RTL

- Producer stage on the write (A) side of the ping-pong frame buffer; runs entirely in the clka domain.
- Takes an 8-bit sample stream (ADC front end), applies decimation and an optional level trigger, and writes 128-sample frames as addra/wea/dina.
- Pulses finisha after each complete frame, then waits for readya before capturing the next frame.

---
 rtl/pingpong_pkg.sv | 26 ++
 rtl/pingpong_frame_writer_if.sv | 42 ++++
 rtl/pp_trig_detect.sv | 53 +++++
 rtl/pingpong_frame_writer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// pingpong_pkg
// Shared constants and types for the write (A) side of the ping-pong frame
// buffer. Imported by the frame writer, its trigger detector and the bus
// interface.
//   ADDR_W  : frame address width
//   DATA_W  : sample width
//   DEPTH   : samples per frame (2**ADDR_W)
//   state_t : frame writer state encoding
package pingpong_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   // WAIT_RDY : idle, waiting for the buffer side to offer a free frame
   // ARM      : hunting for the trigger (or the first sample in free-run)
   // CAPTURE  : writing the remaining samples of the frame
   // FINISH   : one cycle that announces the completed frame
   typedef enum logic [1:0] {
      WAIT_RDY = 2'd0,
      ARM      = 2'd1,
      CAPTURE  = 2'd2,
      FINISH   = 2'd3
   } state_t;

endpackage

// File: rtl/pingpong_frame_writer_if.sv
// pingpong_frame_writer_if
// Bundles the sample stream coming in from the ADC front end and the A-side
// write port of the ping-pong buffer.
//   s_valid, s_data : sample strobe and unsigned sample
//   readya          : buffer A side ready for a new frame
//   addra/wea/dina  : frame write port
//   finisha         : one-cycle frame-complete pulse
// Modports:
//   master : the frame writer (consumes samples, drives the write port)
//   slave  : the environment (sample source plus buffer)
interface pingpong_frame_writer_if;
   import pingpong_pkg::*;

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              readya;
   logic [ADDR_W-1:0] addra;
   logic              wea;
   logic [DATA_W-1:0] dina;
   logic              finisha;

   modport master (
      input  s_valid,
      input  s_data,
      input  readya,
      output addra,
      output wea,
      output dina,
      output finisha
   );

   modport slave (
      output s_valid,
      output s_data,
      output readya,
      input  addra,
      input  wea,
      input  dina,
      input  finisha
   );

endinterface

// File: rtl/pp_trig_detect.sv
// pp_trig_detect
// Level-crossing detector for the frame writer. Remembers the previously
// accepted (non-triggering) sample and compares it against the current one.
//   clka     : clock
//   rstb     : synchronous active-high reset
//   clear    : forget the previous sample (asserted on ARM entry)
//   update   : store cur as the previous sample
//   cur      : current sample
//   level    : trigger threshold (unsigned)
//   rising   : 1 = rising crossing, 0 = falling crossing
//   crossing : combinational crossing indication for cur
module pp_trig_detect
   import pingpong_pkg::*;
(
   input  logic              clka,
   input  logic              rstb,
   input  logic              clear,
   input  logic              update,
   input  logic [DATA_W-1:0] cur,
   input  logic [DATA_W-1:0] level,
   input  logic              rising,
   output logic              crossing
);

   logic [DATA_W-1:0] prev;
   logic              prev_valid;

   // A fresh frame must not trigger against a sample left over from the
   // previous arming, so clear behaves like a local reset.
   always_ff @(posedge clka) begin
      if (rstb || clear) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (update) begin
         prev       <= cur;
         prev_valid <= 1'b1;
      end
   end

   // The threshold itself counts as the far side of the crossing, so a ramp
   // that lands exactly on the level triggers.
   always_comb begin
      crossing = 1'b0;
      if (prev_valid) begin
         if (rising) begin
            crossing = (prev < level) && (cur >= level);
         end else begin
            crossing = (prev > level) && (cur <= level);
         end
      end
   end

endmodule

// File: rtl/pingpong_frame_writer.sv
// pingpong_frame_writer
// Producer on the write (A) side of the ping-pong frame buffer. Decimates an
// 8-bit sample stream, optionally waits for a level crossing, then writes one
// DEPTH-sample frame at addresses 0..DEPTH-1, pulses finisha and waits for
// readya before capturing again.
//   clka            : clock, rising edge
//   rstb            : synchronous active-high reset
//   bus             : sample stream + A-side write port (master modport)
//   cfg_decim       : keep 1 of every cfg_decim+1 valid samples
//   cfg_trig_en     : 1 = start on level crossing, 0 = free-run
//   cfg_trig_rising : 1 = rising crossing, 0 = falling
//   cfg_trig_level  : trigger threshold
//   busy            : high in ARM, CAPTURE and FINISH
//   frame_cnt       : completed frames, wrapping
//   drop_cnt        : samples discarded in WAIT_RDY/FINISH, saturating
module pingpong_frame_writer
   import pingpong_pkg::*;
#(
   parameter int DECIM_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic                    clka,
   input  logic                    rstb,
   pingpong_frame_writer_if.master bus,
   input  logic [DECIM_W-1:0]      cfg_decim,
   input  logic                    cfg_trig_en,
   input  logic                    cfg_trig_rising,
   input  logic [DATA_W-1:0]       cfg_trig_level,
   output logic                    busy,
   output logic [CNT_W-1:0]        frame_cnt,
   output logic [CNT_W-1:0]        drop_cnt
);

   state_t              state;
   logic [DECIM_W-1:0]  decim_cnt;
   logic [DECIM_W-1:0]  decim_cfg;
   logic                trig_en_cfg;
   logic                trig_rising_cfg;
   logic [DATA_W-1:0]   trig_level_cfg;
   logic [ADDR_W-1:0]   idx;

   logic                capturing;
   logic                accept;
   logic                crossing;
   logic                trig_hit;
   logic                trig_update;
   logic                trig_clear;
   logic                dropping;

   assign capturing   = (state == ARM) || (state == CAPTURE);
   assign accept      = bus.s_valid && capturing && (decim_cnt == '0);
   assign trig_hit    = !trig_en_cfg || crossing;
   assign trig_update = accept && (state == ARM) && !trig_hit;
   assign trig_clear  = (state == WAIT_RDY) && bus.readya;
   assign dropping    = bus.s_valid && ((state == WAIT_RDY) || (state == FINISH));

   pp_trig_detect u_trig (
      .clka     (clka),
      .rstb     (rstb),
      .clear    (trig_clear),
      .update   (trig_update),
      .cur      (bus.s_data),
      .level    (trig_level_cfg),
      .rising   (trig_rising_cfg),
      .crossing (crossing)
   );

   // Frame sequencer. wea/finisha default low every cycle so each write and
   // each frame-complete pulse lasts exactly one cycle. The configuration is
   // only sampled on ARM entry so that mid-frame changes cannot tear a frame.
   always_ff @(posedge clka) begin
      if (rstb) begin
         state           <= WAIT_RDY;
         decim_cnt       <= '0;
         decim_cfg       <= '0;
         trig_en_cfg     <= 1'b0;
         trig_rising_cfg <= 1'b0;
         trig_level_cfg  <= '0;
         idx             <= '0;
         bus.addra       <= '0;
         bus.wea         <= 1'b0;
         bus.dina        <= '0;
         bus.finisha     <= 1'b0;
         busy            <= 1'b0;
         frame_cnt       <= '0;
         drop_cnt        <= '0;
      end else begin
         bus.wea     <= 1'b0;
         bus.finisha <= 1'b0;

         if (dropping && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end

         // Decimation counts every valid sample while the frame is open,
         // accepted or not; a zero count marks the sample to keep.
         if (bus.s_valid && capturing) begin
            if (decim_cnt == '0) begin
               decim_cnt <= decim_cfg;
            end else begin
               decim_cnt <= decim_cnt - DECIM_W'(1);
            end
         end

         case (state)
            WAIT_RDY: begin
               if (bus.readya) begin
                  state           <= ARM;
                  busy            <= 1'b1;
                  decim_cnt       <= '0;
                  decim_cfg       <= cfg_decim;
                  trig_en_cfg     <= cfg_trig_en;
                  trig_rising_cfg <= cfg_trig_rising;
                  trig_level_cfg  <= cfg_trig_level;
               end
            end
            ARM: begin
               if (accept && trig_hit) begin
                  bus.wea   <= 1'b1;
                  bus.addra <= '0;
                  bus.dina  <= bus.s_data;
                  idx       <= ADDR_W'(1);
                  state     <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  bus.wea   <= 1'b1;
                  bus.addra <= idx;
                  bus.dina  <= bus.s_data;
                  idx       <= idx + ADDR_W'(1);
                  if (idx == ADDR_W'(DEPTH - 1)) begin
                     state <= FINISH;
                  end
               end
            end
            FINISH: begin
               bus.finisha <= 1'b1;
               frame_cnt   <= frame_cnt + CNT_W'(1);
               busy        <= 1'b0;
               state       <= WAIT_RDY;
            end
            default: begin
               state <= WAIT_RDY;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
